// File: rtl/program_loader_if.sv
// -----------------------------------------------------------------------------
// program_loader_if
//   Bundles the image byte stream (valid/ready) and the instruction-memory
//   write port used by program_loader.
//
//   Signals:
//     in_data   image byte from the upstream source
//     in_valid  in_data is valid
//     in_ready  loader accepts a byte this cycle
//     mem_we    memory write strobe
//     mem_addr  memory write address
//     mem_wdata memory write data
//
//   Modports:
//     master  loader side: consumes the stream, drives the memory port
//     slave   environment side: drives the stream, observes the memory port
// -----------------------------------------------------------------------------
interface program_loader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Streams a program image into the CPU instruction/data memory starting at
//   address 0, pulses the CPU reset, releases the CPU, waits for halt and
//   reports completion together with the number of cycles the CPU ran.
//
//   Ports:
//     clk        rising-edge clock shared with the CPU
//     rst        asynchronous active-low reset
//     bus        stream + memory write port (program_loader_if.master)
//     start      one-cycle request to load and run a program
//     abort      forces a return to IDLE from any state
//     load_len   image byte count, legal 1..2**ADDR_WIDTH, sampled on start
//     cpu_rst    active-high reset to the CPU
//     cpu_halt   CPU halt flag (only observed while running)
//     busy       high while loading, resetting the CPU or running
//     done       high once the CPU has halted
//     err        one-cycle pulse when start carries an illegal load_len
//     run_cycles clock edges spent running, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int RST_HOLD   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    program_loader_if.master      bus,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   load_len,
    output logic                  cpu_rst,
    input  logic                  cpu_halt,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           run_cycles
);

    localparam int LW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int HW    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [LW-1:0] MAX_LEN   = LW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_RST_CPU = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_HALTED  = 3'd4;

    logic [2:0]    state;
    logic [LW-1:0] len_q;
    // One bit wider than the address so a full-depth image can be counted.
    logic [LW-1:0] byte_cnt;
    logic [HW-1:0] hold_cnt;
    logic [15:0]   run_cnt;
    logic          err_q;

    logic          len_ok;
    logic          handshake;
    logic          last_byte;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
    assign handshake = bus.in_valid && (state == S_LOAD);
    assign last_byte = ((byte_cnt + LW'(1)) == len_q);

    // The write strobe is combinational so a byte lands in memory in the
    // very cycle it is accepted, including an abort cycle.
    assign bus.in_ready  = (state == S_LOAD);
    assign bus.mem_we    = handshake;
    assign bus.mem_addr  = byte_cnt[ADDR_WIDTH-1:0];
    assign bus.mem_wdata = bus.in_data;

    // The CPU is held in reset everywhere except while running and halted;
    // keeping it released in HALTED leaves it parked on its halt.
    assign cpu_rst    = !((state == S_RUN) || (state == S_HALTED));
    assign busy       = (state == S_LOAD) || (state == S_RST_CPU) || (state == S_RUN);
    assign done       = (state == S_HALTED);
    assign err        = err_q;
    assign run_cycles = run_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            byte_cnt <= '0;
            hold_cnt <= '0;
            run_cnt  <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (abort) begin
                // run_cnt deliberately keeps its value across an abort.
                state    <= S_IDLE;
                byte_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE, S_HALTED: begin
                        if (start) begin
                            if (len_ok) begin
                                len_q    <= load_len;
                                byte_cnt <= '0;
                                run_cnt  <= '0;
                                state    <= S_LOAD;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (handshake) begin
                            byte_cnt <= byte_cnt + LW'(1);
                            if (last_byte) begin
                                hold_cnt <= '0;
                                state    <= S_RST_CPU;
                            end
                        end
                    end
                    S_RST_CPU: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state <= S_RUN;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    S_RUN: begin
                        // The halting edge itself is not counted.
                        if (cpu_halt) begin
                            state <= S_HALTED;
                        end else begin
                            run_cnt <= sat_inc(run_cnt);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
